// File: rtl/rv32i_types.sv
// Shared types for the memory-port arbiter.
// FSM state and the latched downstream request bundle.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// One request outstanding; stale fetch responses are dropped.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  input  logic        mispredict_br_en,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);
  import rv32i_types::*;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  mem_req_t   req;
  logic [3:0] starve;
  logic       stale;

  logic dreq;
  logic ireq;
  logic grant_i;
  logic grant_d;

  // A redirect cycle never grants a fetch: the pc is about to change.
  always_comb begin
    dreq    = (|dmem_rmask) | (|dmem_wmask);
    ireq    = (|imem_rmask) & ~mispredict_br_en;
    grant_i = ireq & (~dreq | (starve == LIMIT));
    grant_d = dreq & ~grant_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      req    <= '0;
      starve <= '0;
      stale  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          stale <= 1'b0;
          if (grant_i) begin
            state     <= BUSY_I;
            req.addr  <= imem_addr;
            req.rmask <= imem_rmask;
            req.wmask <= '0;
            req.wdata <= '0;
            starve    <= '0;
          end else if (grant_d) begin
            state     <= BUSY_D;
            req.addr  <= dmem_addr;
            req.rmask <= dmem_rmask;
            req.wmask <= dmem_wmask;
            req.wdata <= dmem_wdata;
            if (!ireq)
              starve <= '0;
            else if (starve != LIMIT)
              starve <= starve + 4'd1;
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_resp) begin
            state     <= IDLE;
            req.rmask <= '0;
            req.wmask <= '0;
            stale     <= 1'b0;
          end else if (state == BUSY_I && mispredict_br_en) begin
            stale <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr  = req.addr;
  assign mem_rmask = req.rmask;
  assign mem_wmask = req.wmask;
  assign mem_wdata = req.wdata;

  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;

  assign dmem_resp = (state == BUSY_D) & mem_resp;
  assign imem_resp = (state == BUSY_I) & mem_resp & ~stale
                   & ~mispredict_br_en & (imem_addr == req.addr);

  a_dmem_rw_excl: assert property (@(posedge clk) disable iff (rst)
    !((|dmem_rmask) && (|dmem_wmask)));

endmodule
